instruction_prefetch_unit: RTL

//   Word-aligned instruction fetch engine that sits between memory_controller and processor decode.

---
 rtl/instruction_prefetch_unit_pkg.sv | 21 ++
 rtl/instruction_prefetch_unit_fifo.sv | 79 +++++++
 rtl/instruction_prefetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/instruction_prefetch_unit_pkg.sv
// Bus encodings, fetch FSM states and FIFO entry sizing shared by the prefetch unit.
package limb_bus_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam int         PROT_OPCODE  = 0;
  localparam int         PROT_PRIV    = 1;

  typedef enum logic [0:0] {
    ST_RUN        = 1'b0,
    ST_ABORT_HOLD = 1'b1
  } fetch_state_e;

  // FIFO entry layout is {addr, data, abort}.
  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

endpackage

// File: rtl/instruction_prefetch_unit_fifo.sv
// Synchronous FIFO with flush; the head reads as zero while empty.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign dout  = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Pointer, occupancy and storage next-state; flush wins over push/pop.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Word-aligned opcode fetch engine feeding decode through a small prefetch FIFO.
// Optional PREFETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module instruction_prefetch_unit
  import limb_bus_pkg::*;
#(
  parameter int                DEPTH        = 4,
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_trans,
  output logic [1:0]        mem_size,
  output logic [1:0]        mem_prot,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_abort,
  input  logic              priv,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_abort
);

  localparam int              EW      = entry_width(ADDR_W, DATA_W);
  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_trans_q, mem_trans_d;
  logic [1:0]        mem_prot_q, mem_prot_d;
  logic              pending_q, pending_d;
  fetch_state_e      state_q, state_d;

  logic [CW-1:0]     count_s;
  logic [CW:0]       occupancy_s;
  logic              full_s, empty_s, issue_s, resp_s;
  logic              fifo_push_s, fifo_pop_s;
  logic [EW-1:0]     fifo_din_s, fifo_dout_s;

  assign mem_addr   = mem_addr_q;
  assign mem_trans  = mem_trans_q;
  assign mem_prot   = mem_prot_q;
  assign mem_size   = SIZE_WORD;
  assign mem_write  = 1'b0;
  assign fifo_din_s = {mem_addr_q, mem_rdata, mem_abort};

  prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .flush (branch_valid),
    .din   (fifo_din_s),
    .dout  (fifo_dout_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Issue gating counts the outstanding response so a full FIFO is never pushed.
  always_comb begin
    occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, pending_q};
    issue_s     = (state_q == ST_RUN) && !branch_valid && (occupancy_s < DEPTH_C) && !full_s;
    resp_s      = pending_q && !branch_valid;
    fifo_pop_s  = instr_ready && !empty_s;
`ifdef PREFETCH_BYPASS_EN
    fifo_push_s = resp_s && !(empty_s && instr_ready);
    instr_valid = !empty_s || resp_s;
    if (empty_s && resp_s) begin
      {instr_addr, instr, instr_abort} = fifo_din_s;
    end else begin
      {instr_addr, instr, instr_abort} = fifo_dout_s;
    end
`else
    fifo_push_s = resp_s;
    instr_valid = !empty_s;
    {instr_addr, instr, instr_abort} = fifo_dout_s;
`endif
  end

  // Fetch FSM next-state and bus request generation.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    mem_addr_d  = mem_addr_q;
    mem_trans_d = TRANS_IDLE;
    mem_prot_d  = mem_prot_q;
    pending_d   = 1'b0;
    state_d     = state_q;
    if (branch_valid) begin
      fetch_pc_d = branch_target & ~ADDR_W'(3);
      state_d    = ST_RUN;
    end else begin
      if (issue_s) begin
        mem_trans_d            = (mem_trans_q == TRANS_IDLE) ? TRANS_NONSEQ : TRANS_SEQ;
        mem_addr_d             = fetch_pc_q;
        fetch_pc_d             = fetch_pc_q + ADDR_W'(4);
        mem_prot_d[PROT_PRIV]  = priv;
        mem_prot_d[PROT_OPCODE] = 1'b0;
        pending_d              = 1'b1;
      end else begin
        mem_trans_d = TRANS_IDLE;
        pending_d   = 1'b0;
      end
      case (state_q)
        ST_RUN: begin
          if (resp_s && mem_abort) state_d = ST_ABORT_HOLD;
          else                     state_d = ST_RUN;
        end
        ST_ABORT_HOLD: state_d = ST_ABORT_HOLD;
        default:       state_d = ST_RUN;
      endcase
    end
  end

  // Fetch engine state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_VECTOR;
      mem_addr_q  <= RESET_VECTOR;
      mem_trans_q <= TRANS_IDLE;
      mem_prot_q  <= 2'b00;
      pending_q   <= 1'b0;
      state_q     <= ST_RUN;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_trans_q <= mem_trans_d;
      mem_prot_q  <= mem_prot_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
    end
  end

endmodule
